// File: rtl/inst_fetch_axil_if.sv
// inst_fetch_axil_if: AXI4-Lite read-address/read-data channels of the fetch port.
interface inst_fetch_axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PROT_WIDTH = 3,
    parameter int RESP_WIDTH = 2
);
    logic                  m_axi_arvalid_fe;
    logic                  m_axi_arready_fe;
    logic [ADDR_WIDTH-1:0] m_axi_araddr_fe;
    logic [PROT_WIDTH-1:0] m_axi_arprot_fe;
    logic                  m_axi_rvalid_fe;
    logic                  m_axi_rready_fe;
    logic [DATA_WIDTH-1:0] m_axi_rdata_fe;
    logic [RESP_WIDTH-1:0] m_axi_rresp_fe;

    modport master (
        output m_axi_arvalid_fe, m_axi_araddr_fe, m_axi_arprot_fe, m_axi_rready_fe,
        input  m_axi_arready_fe, m_axi_rvalid_fe, m_axi_rdata_fe, m_axi_rresp_fe
    );

    modport slave (
        input  m_axi_arvalid_fe, m_axi_araddr_fe, m_axi_arprot_fe, m_axi_rready_fe,
        output m_axi_arready_fe, m_axi_rvalid_fe, m_axi_rdata_fe, m_axi_rresp_fe
    );
endinterface

// File: rtl/inst_fetch_axil.sv
// inst_fetch_axil: RV32I fetch front-end, one AXI4-Lite read per instruction into a
// first-word-fall-through buffer, with redirect flush and fault halt.
module inst_fetch_axil #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PROT_WIDTH = 3,
    parameter int RESP_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH-1:0] i_boot_addr,
    inst_fetch_axil_if.master     m_axi,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_inst_valid,
    output logic [DATA_WIDTH-1:0] o_inst_data,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    output logic                  o_inst_fault,
    input  logic                  i_inst_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {S_BOOT, S_IDLE, S_AR, S_R, S_HALT} state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [ADDR_WIDTH-1:0] r_fetch_addr, w_fetch_addr_next;
    logic                  r_discard, w_discard_next;
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_fault;
    logic [PTR_W-1:0]      r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0]      r_count, w_count_next;
    logic                  w_redirect, w_beat, w_fault, w_push, w_pop, w_space;

    assign w_redirect   = i_redirect_valid && (r_state != S_BOOT);
    assign w_beat       = (r_state == S_R) && m_axi.m_axi_rvalid_fe;
    assign w_fault      = m_axi.m_axi_rresp_fe != '0;
    assign w_push       = w_beat && !r_discard && !w_redirect;
    assign w_pop        = o_inst_valid && i_inst_ready && !w_redirect;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_space      = w_count_next < CNT_W'(FIFO_DEPTH);

    assign m_axi.m_axi_arvalid_fe = r_state == S_AR;
    assign m_axi.m_axi_rready_fe  = r_state == S_R;
    assign m_axi.m_axi_araddr_fe  = r_fetch_addr;
    assign m_axi.m_axi_arprot_fe  = PROT_WIDTH'(3'b100);

    assign o_inst_valid = r_count != '0;
    assign o_inst_data  = r_fifo_data[r_rd_ptr];
    assign o_inst_pc    = r_fifo_pc[r_rd_ptr];
    assign o_inst_fault = r_fifo_fault[r_rd_ptr];

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_fetch_addr_next = r_fetch_addr;
        w_discard_next    = r_discard;
        case (r_state)
            S_BOOT: begin
                w_pc_next    = i_boot_addr & ~ADDR_WIDTH'(3);
                w_state_next = S_IDLE;
            end
            S_IDLE: begin
                if (w_space) begin
                    w_fetch_addr_next = r_pc;
                    w_pc_next         = r_pc + ADDR_WIDTH'(4);
                    w_state_next      = S_AR;
                end
            end
            S_AR: w_state_next = m_axi.m_axi_arready_fe ? S_R : S_AR;
            S_R: begin
                if (m_axi.m_axi_rvalid_fe) begin
                    w_discard_next = 1'b0;
                    if (w_push && w_fault) begin
                        w_state_next = S_HALT;
                    end else if (w_space) begin
                        w_fetch_addr_next = r_pc;
                        w_pc_next         = r_pc + ADDR_WIDTH'(4);
                        w_state_next      = S_AR;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_BOOT;
        endcase
        // An accepted or pending AR must still complete its R beat, so it is marked for dropping.
        if (w_redirect) begin
            w_pc_next = i_redirect_pc & ~ADDR_WIDTH'(3);
            if (r_state == S_AR || (r_state == S_R && !m_axi.m_axi_rvalid_fe)) begin
                w_discard_next = 1'b1;
            end else begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_BOOT;
            r_pc         <= '0;
            r_fetch_addr <= '0;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_discard    <= w_discard_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_fifo_fault <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (w_redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= m_axi.m_axi_rdata_fe;
                r_fifo_pc[r_wr_ptr]    <= r_fetch_addr;
                r_fifo_fault[r_wr_ptr] <= w_fault;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end
endmodule

// File: doc/inst_fetch_axil.md
# inst_fetch_axil

Instruction fetch front-end for the RV32I core. Walks the PC from `BOOT_ADDR`, issues one AXI4-Lite read per instruction on the `_fe` AR/R channels toward instruction memory, and buffers returned words with their PC in a small FIFO for decode. It handles branch/trap redirects by flushing the buffer and discarding any in-flight read. Faulting reads are tagged and stop fetch until the next redirect.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: instruction width.
- `PROT_WIDTH`, 3: AXI prot width.
- `RESP_WIDTH`, 2: AXI resp width.
- `FIFO_DEPTH`, 4: instruction buffer entries, power of 2, at least 2.

- `CLK` in 1: core clock, the only clock.
- `RSTN` in 1: asynchronous, active-low reset.
- `BOOT_ADDR` in ADDR_WIDTH: initial PC, sampled once after reset release.
- `m_axi_arready_fe` in 1: AR ready.
- `m_axi_arvalid_fe` out 1: AR valid.
- `m_axi_araddr_fe` out ADDR_WIDTH: AR address.
- `m_axi_arprot_fe` out PROT_WIDTH: constant 3'b100 (instruction, secure, unprivileged).
- `m_axi_rvalid_fe` in 1: R valid.
- `m_axi_rdata_fe` in DATA_WIDTH: R data.
- `m_axi_rresp_fe` in RESP_WIDTH: R response; any value other than 0 is a fault.
- `m_axi_rready_fe` out 1: R ready.
- `redirect_valid` in 1: one-cycle redirect request.
- `redirect_pc` in ADDR_WIDTH: redirect target; bits [1:0] are forced to 0.
- `inst_valid` out 1: FIFO head valid.
- `inst_data` out DATA_WIDTH: head instruction.
- `inst_pc` out ADDR_WIDTH: head PC.
- `inst_fault` out 1: head is a fetch fault.
- `inst_ready` in 1: decode accepts the head.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `fetch_addr`: drives araddr.
  - `discard`: set while an in-flight read must be dropped.
  - FIFO storage, `count` (0..FIFO_DEPTH), and wrapping rd/wr pointers.
- States: BOOT, IDLE, AR, R, HALT. Reset state is BOOT.
  - BOOT: `pc <= BOOT_ADDR & ~3`; go to IDLE.
  - IDLE: if `count_next < FIFO_DEPTH`, load `fetch_addr <= pc`, `pc <= pc + 4` (mod 2^ADDR_WIDTH), and go to AR.
  - AR: `arvalid = 1`. On `arready`, go to R.
  - R: `rready = 1`. On `rvalid`:
    - Push {rdata, fetch_addr, rresp != 0} unless `discard`; clear `discard`.
    - If a fault was pushed, go to HALT.
    - Else, if there is space, load the next fetch as in IDLE and go to AR.
    - Else go to IDLE.
  - HALT: no requests issued; leave only on redirect.
- Redirect (highest priority, any state except BOOT):
  - `pc <= redirect_pc & ~3`.
  - FIFO flushed: count 0, pointers equal. A pop or push in the same cycle is suppressed.
  - In AR: stay in AR and keep `arvalid`/`araddr` stable until the handshake (AXI rule); set `discard`.
  - In R without `rvalid` this cycle: set `discard`.
  - In R with `rvalid`, or in IDLE/HALT: the beat (if any) is dropped and the state goes to IDLE.
  - A redirect arriving while `discard` is already set leaves it set; only one read is ever outstanding.
- FIFO:
  - First-word fall-through: `inst_valid = (count != 0)`, and head fields are driven from the rd pointer.
  - Pop on `inst_valid & inst_ready`.
  - `count_next = count + push - pop`. Push and pop in the same cycle at full is legal and is counted in the space check.
  - Push never occurs when full, because issue is gated on space.

## Timing
- Reset values: arvalid 0, araddr 0, rready 0, inst_valid 0, inst_data 0, inst_pc 0, inst_fault 0, discard 0, count 0. arprot is always 3'b100.
- First `arvalid` occurs in the 2nd cycle after RSTN deasserts (BOOT, IDLE, then AR).
- All outputs except the head fields are registered. The head fields come from the FIFO storage registers.
- Peak throughput with zero-wait memory: 1 instruction per 2 cycles (AR, R, AR, R ...).
- A pushed word is visible on `inst_*` the cycle after the R handshake.
- After a redirect in IDLE/HALT: `arvalid` asserts 2 cycles later, with `araddr = redirect_pc`.
- Reset mid-transaction: all state clears asynchronously. Any R beat arriving after reset release while in BOOT/IDLE is ignored (`rready` = 0).

## Test plan
- Boot: BOOT_ADDR=0xFFFF_0000, zero-wait memory returning addr-derived data -> araddr sequence 0xFFFF_0000, _0004, _0008...; inst_pc matches; arvalid first high in 2nd cycle after reset release.
- Backpressure: inst_ready=0 -> exactly 4 entries pushed, arvalid stays 0. Then inst_ready=1 for one cycle -> 1 pop and 1 new AR, with space checked at simultaneous push/pop.
- Redirect in AR with arready held low 3 cycles -> araddr stays the old value; R beat dropped (no push); next araddr = redirect_pc (0x0000_0100); FIFO empty after redirect.
- Fault: rresp=2'b10 on address 0x0000_0008 -> entry with inst_fault=1, inst_pc=0x0000_0008; no further AR. Redirect to 0x0000_0040 -> fetch resumes at 0x0000_0040.
- Redirect coincident with R beat and pop -> beat dropped, count=0, inst_valid=0 next cycle, discard=0.
- Reset asserted while in R -> arvalid/rready/inst_valid 0 immediately. After release, fetch restarts at BOOT_ADDR.
